// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   D-stage stall/flush and forwarding controller for a MIPS-style pipeline.
//   Tracks the destination register and remaining latency (Tnew) of every
//   instruction in the DEPTH stages after decode (stage 0 = E, 1 = M, 2 = W).
//   A busy counter also tracks the multi-cycle mult/div unit (MDU).
//
//   Optional feature: define HAZ_STAT_EN to add the stall statistics counters
//   stat_stall_raw / stat_stall_md.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   d_valid             D holds a real instruction
//   d_a1, d_a2          D source registers
//   d_tuse1, d_tuse2    cycles until D needs each source
//   d_a3, d_tnew        D destination register (0 = none) and its Tnew at E
//   d_md_start          D is mult/multu/div/divu
//   d_md_div            the MDU op is a divide
//   d_md_use            D accesses HI/LO or the MDU
//   flush               kill every in-flight scoreboard entry
//   stall               hold PC and D
//   en_pc, en_d         ~stall
//   flush_e             stall; inserts a bubble into E
//   md_busy             MDU counter non-zero
//   fwd_d               D operand selects {a2, a1}; value j+1 = from stage j
//   fwd_s               per-stage operand selects, slice k = {a2, a1} of the
//                       instruction held in stage k (top slice always 0)
//   stat_stall_raw      (HAZ_STAT_EN) cycles stalled on a register hazard
//   stat_stall_md       (HAZ_STAT_EN) cycles stalled only on the MDU
module hazard_scoreboard #(
    parameter int NREG     = 32,
    parameter int DEPTH    = 3,
    parameter int TW       = 2,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CW       = 4,
    localparam int RW      = $clog2(NREG),
    localparam int SW      = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    d_valid,
    input  logic [RW-1:0]           d_a1,
    input  logic [RW-1:0]           d_a2,
    input  logic [TW-1:0]           d_tuse1,
    input  logic [TW-1:0]           d_tuse2,
    input  logic [RW-1:0]           d_a3,
    input  logic [TW-1:0]           d_tnew,
    input  logic                    d_md_start,
    input  logic                    d_md_div,
    input  logic                    d_md_use,
    input  logic                    flush,
    output logic                    stall,
    output logic                    en_pc,
    output logic                    en_d,
    output logic                    flush_e,
    output logic                    md_busy,
    output logic [2*SW-1:0]         fwd_d,
`ifdef HAZ_STAT_EN
    output logic [DEPTH*2*SW-1:0]   fwd_s,
    output logic [31:0]             stat_stall_raw,
    output logic [31:0]             stat_stall_md
`else
    output logic [DEPTH*2*SW-1:0]   fwd_s
`endif
);

    // Match word layout: {hit, select (j+1), tnew of the winning entry}.
    localparam int MW = 1 + SW + TW;
    localparam int HB = MW - 1;

    logic [DEPTH-1:0] ent_valid;
    logic [RW-1:0]    ent_a1   [DEPTH];
    logic [RW-1:0]    ent_a2   [DEPTH];
    logic [RW-1:0]    ent_a3   [DEPTH];
    logic [TW-1:0]    ent_tnew [DEPTH];
    logic [CW-1:0]    md_cnt;

    logic             raw_stall;
    logic             md_stall;
    logic             issue;
    logic [MW-1:0]    d_m;
    logic [MW-1:0]    s_m;

    // Search entries lo..DEPTH-1 for a writer of src. Scanning from the oldest
    // towards the youngest lets the nearest (lowest index) match overwrite.
    // Register 0 is never a hazard, so entries with a3 == 0 never match.
    function automatic logic [MW-1:0] find_match(input logic [RW-1:0] src, input int lo);
        logic [MW-1:0] r;
        r = '0;
        for (int j = DEPTH - 1; j >= lo; j--) begin
            if (ent_valid[j] && (ent_a3[j] != '0) && (ent_a3[j] == src)) begin
                r = {1'b1, SW'(j + 1), ent_tnew[j]};
            end
        end
        return r;
    endfunction

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

    // D-stage operands: stall when the value arrives too late, forward only
    // when the nearest producer already has its result (tnew == 0). An older
    // match behind a not-yet-ready nearer one is deliberately ignored.
    always_comb begin
        raw_stall = 1'b0;
        fwd_d     = '0;
        d_m       = '0;
        for (int op = 0; op < 2; op++) begin
            d_m = find_match((op == 0) ? d_a1 : d_a2, 0);
            if (d_m[HB] && (d_m[TW-1:0] > ((op == 0) ? d_tuse1 : d_tuse2))) begin
                raw_stall = 1'b1;
            end
            if (d_m[HB] && (d_m[TW-1:0] == '0)) begin
                fwd_d[op*SW +: SW] = d_m[TW +: SW];
            end
        end
    end

    // Operands of the instruction held in stage k may only take values from
    // older instructions, i.e. entries j > k.
    always_comb begin
        fwd_s = '0;
        s_m   = '0;
        for (int k = 0; k < DEPTH - 1; k++) begin
            for (int op = 0; op < 2; op++) begin
                s_m = find_match((op == 0) ? ent_a1[k] : ent_a2[k], k + 1);
                if (ent_valid[k] && s_m[HB] && (s_m[TW-1:0] == '0)) begin
                    fwd_s[(2*k + op)*SW +: SW] = s_m[TW +: SW];
                end
            end
        end
    end

    assign md_busy  = (md_cnt != '0);
    assign md_stall = d_valid && d_md_use && md_busy;
    assign stall    = raw_stall || md_stall;
    assign en_pc    = ~stall;
    assign en_d     = ~stall;
    assign flush_e  = stall;
    assign issue    = d_valid && !stall && !flush;

    // Scoreboard pipeline. flush clears every valid bit, including the
    // incoming slot, since issue already excludes flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_valid <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                ent_a1[k]   <= '0;
                ent_a2[k]   <= '0;
                ent_a3[k]   <= '0;
                ent_tnew[k] <= '0;
            end
        end else begin
            for (int k = 1; k < DEPTH; k++) begin
                ent_valid[k] <= ent_valid[k-1] && !flush;
                ent_a1[k]    <= ent_a1[k-1];
                ent_a2[k]    <= ent_a2[k-1];
                ent_a3[k]    <= ent_a3[k-1];
                ent_tnew[k]  <= sat_dec(ent_tnew[k-1]);
            end
            if (issue) begin
                ent_valid[0] <= 1'b1;
                ent_a1[0]    <= d_a1;
                ent_a2[0]    <= d_a2;
                ent_a3[0]    <= d_a3;
                ent_tnew[0]  <= d_tnew;
            end else begin
                ent_valid[0] <= 1'b0;
                ent_a1[0]    <= '0;
                ent_a2[0]    <= '0;
                ent_a3[0]    <= '0;
                ent_tnew[0]  <= '0;
            end
        end
    end

    // MDU busy counter. A running count survives flush; an MDU op only loads
    // it when it actually issues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt <= '0;
        end else if (issue && d_md_start) begin
            md_cnt <= d_md_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - CW'(1);
        end
    end

`ifdef HAZ_STAT_EN
    // A cycle with both causes is attributed to the register hazard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_stall_raw <= '0;
            stat_stall_md  <= '0;
        end else if (raw_stall) begin
            stat_stall_raw <= stat_stall_raw + 32'd1;
        end else if (md_stall) begin
            stat_stall_md  <= stat_stall_md + 32'd1;
        end
    end
`endif

endmodule
